// File: rtl/inst_issue_queue.sv
// Instruction issue queue: buffers host-written macro-instructions in a FIFO and
// issues them one at a time to the controller, keeping exactly one in flight.
module inst_issue_queue #(
   parameter int INST_WIDTH = 27,
   parameter int DEPTH      = 8,
   parameter int PTR_W      = 3,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  host_wr_en,
   input  logic [INST_WIDTH-1:0] host_wr_data,
   output logic                  host_full,
   output logic [PTR_W:0]        host_count,
   input  logic                  run,
   input  logic                  flush,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid,
   input  logic                  inst_accept,
   input  logic                  inst_done,
   output logic                  busy,
   output logic                  prog_done,
   output logic [CNT_W-1:0]      issued_cnt,
   output logic                  err_overflow,
   output logic [1:0]            state_dbg
);

   // Handshake: inst is offered while inst_valid=1 and held unchanged until the
   // controller pulses inst_accept; inst_done later closes the transaction.

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

   localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [INST_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        host_count_q, host_count_d;
   logic                  host_full_q, host_full_d;
   logic                  err_overflow_q, err_overflow_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  busy_q, busy_d;
   logic                  prog_done_q, prog_done_d;
   logic [CNT_W-1:0]      issued_cnt_q, issued_cnt_d;

   logic                  fifo_empty, fifo_full, push, pop, head_is_marker;
   logic [INST_WIDTH-1:0] head;

   assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
   assign fifo_full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                           (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head           = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign head_is_marker = (head[INST_WIDTH-1 -: 3] == 3'b000);

   // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
   assign push = host_wr_en && !flush && (!fifo_full || pop);

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      err_overflow_d = err_overflow_q;
      if (flush) begin
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         err_overflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (host_wr_en && fifo_full && !pop) err_overflow_d = 1'b1;
      end
      host_count_d = wr_ptr_d - rd_ptr_d;
      host_full_d  = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                     (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:      if (run && !fifo_empty && !head_is_marker) state_d = ISSUE;
            ISSUE:     if (inst_accept) state_d = WAIT_DONE;
            WAIT_DONE: if (inst_done) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pop          = 1'b0;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      issued_cnt_d = issued_cnt_q;
      prog_done_d  = 1'b0;
      if (flush) begin
         inst_d       = '0;
         inst_valid_d = 1'b0;
         issued_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               inst_valid_d = 1'b0;
               if (run && !fifo_empty) begin
                  if (head_is_marker) begin
                     pop         = 1'b1;
                     prog_done_d = 1'b1;
                  end else begin
                     inst_d       = head;
                     inst_valid_d = 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (inst_accept) begin
                  pop          = 1'b1;
                  inst_valid_d = 1'b0;
                  issued_cnt_d = issued_cnt_q + CNT_ONE;
               end
            end
            WAIT_DONE: begin
               inst_valid_d = 1'b0;
               // A stopped queue (run=0) never reports completion, even when drained.
               if (inst_done && run && fifo_empty) prog_done_d = 1'b1;
            end
            default: inst_valid_d = 1'b0;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         host_count_q   <= '0;
         host_full_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         inst_q         <= '0;
         inst_valid_q   <= 1'b0;
         busy_q         <= 1'b0;
         prog_done_q    <= 1'b0;
         issued_cnt_q   <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         host_count_q   <= host_count_d;
         host_full_q    <= host_full_d;
         err_overflow_q <= err_overflow_d;
         inst_q         <= inst_d;
         inst_valid_q   <= inst_valid_d;
         busy_q         <= busy_d;
         prog_done_q    <= prog_done_d;
         issued_cnt_q   <= issued_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= host_wr_data;
   end

   assign host_full    = host_full_q;
   assign host_count   = host_count_q;
   assign err_overflow = err_overflow_q;
   assign inst         = inst_q;
   assign inst_valid   = inst_valid_q;
   assign busy         = busy_q;
   assign prog_done    = prog_done_q;
   assign issued_cnt   = issued_cnt_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: FIFO vector table, directed corner
// sequences and randomized programs scored against an instruction-order queue.
module tb_inst_issue_queue;

   localparam int IW = 27;
   localparam int PW = 3;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          host_wr_en = 1'b0;
   logic [IW-1:0] host_wr_data = '0;
   logic          host_full;
   logic [PW:0]   host_count;
   logic          run = 1'b0;
   logic          flush = 1'b0;
   logic [IW-1:0] inst;
   logic          inst_valid;
   logic          inst_accept = 1'b0;
   logic          inst_done = 1'b0;
   logic          busy;
   logic          prog_done;
   logic [CW-1:0] issued_cnt;
   logic          err_overflow;
   logic [1:0]    state_dbg;

   inst_issue_queue #(.INST_WIDTH(IW), .DEPTH(8), .PTR_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
      .host_full(host_full), .host_count(host_count), .run(run), .flush(flush),
      .inst(inst), .inst_valid(inst_valid), .inst_accept(inst_accept),
      .inst_done(inst_done), .busy(busy), .prog_done(prog_done),
      .issued_cnt(issued_cnt), .err_overflow(err_overflow), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int prog_cnt = 0;
   logic [IW-1:0] exp_q[$];

   typedef struct {
      bit            wr;
      bit            fl;
      logic [IW-1:0] data;
      int            exp_cnt;
      bit            exp_full;
      bit            exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [IW-1:0] mk(input logic [2:0] op, input int payload);
      logic [31:0] p;
      p = payload;
      return {op, p[IW-4:0]};
   endfunction

   task automatic push(input logic [IW-1:0] d);
      host_wr_en = 1'b1;
      host_wr_data = d;
      tick();
      host_wr_en = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
         if (inst_valid) ok = 1'b1;
         else tick();
      end
      if (!ok) check("issue_timeout", inst_valid, 1);
   endtask

   task automatic wait_prog(output bit seen);
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (prog_done) seen = 1'b1;
         else tick();
      end
   endtask

   // Controller model: accept after acc_dly cycles, done done_dly cycles later.
   task automatic serve_one(input int acc_dly, input int done_dly);
      bit ok;
      logic [IW-1:0] exp;
      wait_valid(ok);
      if (!ok) return;
      if (exp_q.size() == 0) begin
         check("inst_unexpected", inst_valid, 0);
         return;
      end
      exp = exp_q.pop_front();
      for (int i = 0; i < acc_dly; i++) begin
         tick();
         check("inst_held", inst, exp);
         check("valid_held", inst_valid, 1);
      end
      check("inst_order", inst, exp);
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      check("valid_clear", inst_valid, 0);
      check("busy_wait", busy, 1);
      for (int i = 0; i < done_dly; i++) tick();
      inst_done = 1'b1;
      tick();
      inst_done = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (rstn) begin
         if (prog_done) prog_cnt++;
         if (inst_valid) check("valid_implies_busy", busy, 1);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[12];
      bit ok, seen;
      int p0, k, marker_at, n_iss, remain;
      logic [IW-1:0] d;
      logic [2:0] op;

      for (int i = 0; i < 9; i++) begin
         tbl[i].wr = 1; tbl[i].fl = 0; tbl[i].data = mk(3'b110, i);
         tbl[i].exp_cnt = (i + 1 > 8) ? 8 : i + 1;
         tbl[i].exp_full = (i >= 7); tbl[i].exp_err = (i == 8);
      end
      tbl[9]  = '{wr: 0, fl: 0, data: '0, exp_cnt: 8, exp_full: 1, exp_err: 1};
      tbl[10] = '{wr: 1, fl: 1, data: mk(3'b101, 50), exp_cnt: 0, exp_full: 0, exp_err: 0};
      tbl[11] = '{wr: 1, fl: 0, data: mk(3'b101, 51), exp_cnt: 1, exp_full: 0, exp_err: 0};

      // Reset state
      repeat (2) tick();
      check("rst_inst", inst, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_count", host_count, 0);
      check("rst_full", host_full, 0);
      check("rst_issued", issued_cnt, 0);
      check("rst_err", err_overflow, 0);
      check("rst_prog", prog_done, 0);
      rstn = 1'b1;
      tick();

      // 1: three instructions issued in order, one prog_done at the end
      push(mk(3'b110, 1)); exp_q.push_back(mk(3'b110, 1));
      push(mk(3'b100, 2)); exp_q.push_back(mk(3'b100, 2));
      push(mk(3'b110, 3)); exp_q.push_back(mk(3'b110, 3));
      check("t1_count", host_count, 3);
      p0 = prog_cnt;
      run = 1'b1;
      for (int i = 0; i < 3; i++) serve_one(1, 4);
      wait_prog(seen);
      check("t1_prog_seen", seen, 1);
      repeat (2) tick();
      run = 1'b0;
      check("t1_prog_once", prog_cnt - p0, 1);
      check("t1_busy", busy, 0);
      check("t1_count0", host_count, 0);
      check("t1_issued", issued_cnt, 3);

      // 2: FIFO fill/overflow/flush vector table (run=0)
      for (int i = 0; i < 12; i++) begin
         host_wr_en = tbl[i].wr;
         host_wr_data = tbl[i].data;
         flush = tbl[i].fl;
         tick();
         host_wr_en = 1'b0;
         flush = 1'b0;
         check($sformatf("t2_count[%0d]", i), host_count, tbl[i].exp_cnt);
         check($sformatf("t2_full[%0d]", i), host_full, tbl[i].exp_full);
         check($sformatf("t2_err[%0d]", i), err_overflow, tbl[i].exp_err);
      end
      check("t2_flush_issued", issued_cnt, 0);

      // 3: push onto a full FIFO in the same cycle as inst_accept
      do_flush();
      for (int i = 0; i < 8; i++) begin
         push(mk(3'b100, 20 + i));
         exp_q.push_back(mk(3'b100, 20 + i));
      end
      check("t3_full", host_full, 1);
      run = 1'b1;
      wait_valid(ok);
      check("t3_inst", inst, exp_q.pop_front());
      inst_accept = 1'b1;
      host_wr_en = 1'b1;
      host_wr_data = mk(3'b101, 99);
      tick();
      inst_accept = 1'b0;
      host_wr_en = 1'b0;
      run = 1'b0;
      check("t3_count", host_count, 8);
      check("t3_full_kept", host_full, 1);
      check("t3_err", err_overflow, 0);
      check("t3_issued", issued_cnt, 1);
      inst_done = 1'b1;
      tick();
      inst_done = 1'b0;
      tick();
      check("t3_idle", busy, 0);

      // 4: end marker stops the program with one instruction left queued
      do_flush();
      push(mk(3'b110, 31)); exp_q.push_back(mk(3'b110, 31));
      push(mk(3'b000, 32));
      push(mk(3'b100, 33));
      p0 = prog_cnt;
      run = 1'b1;
      serve_one(1, 2);
      wait_prog(seen);
      run = 1'b0;
      check("t4_prog_seen", seen, 1);
      repeat (3) tick();
      check("t4_count", host_count, 1);
      check("t4_prog_once", prog_cnt - p0, 1);
      check("t4_issued", issued_cnt, 1);
      check("t4_valid", inst_valid, 0);

      // 5: run dropped in ISSUE keeps the offer; resumes when run returns
      do_flush();
      push(mk(3'b110, 41)); exp_q.push_back(mk(3'b110, 41));
      push(mk(3'b100, 42)); exp_q.push_back(mk(3'b100, 42));
      run = 1'b1;
      wait_valid(ok);
      run = 1'b0;
      d = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_inst_held", inst, d);
         check("t5_valid_held", inst_valid, 1);
      end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      tick();
      inst_done = 1'b1;
      tick();
      inst_done = 1'b0;
      p0 = prog_cnt;
      repeat (4) tick();
      check("t5_busy", busy, 0);
      check("t5_no_issue", inst_valid, 0);
      check("t5_no_prog", prog_cnt - p0, 0);
      check("t5_count", host_count, 1);
      check("t5_issued", issued_cnt, 1);
      run = 1'b1;
      serve_one(0, 1);
      wait_prog(seen);
      run = 1'b0;
      check("t5_prog_seen", seen, 1);
      check("t5_issued2", issued_cnt, 2);

      // 6: asynchronous reset in WAIT_DONE, stray inst_done afterwards
      do_flush();
      push(mk(3'b111, 61));
      run = 1'b1;
      wait_valid(ok);
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      tick();
      check("t6_pre_busy", busy, 1);
      rstn = 1'b0;
      #1;
      check("t6_inst", inst, 0);
      check("t6_valid", inst_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_issued", issued_cnt, 0);
      check("t6_count", host_count, 0);
      check("t6_full", host_full, 0);
      check("t6_err", err_overflow, 0);
      check("t6_prog", prog_done, 0);
      tick();
      rstn = 1'b1;
      p0 = prog_cnt;
      inst_done = 1'b1;
      tick();
      inst_done = 1'b0;
      repeat (2) tick();
      run = 1'b0;
      check("t6_stray_busy", busy, 0);
      check("t6_stray_prog", prog_cnt - p0, 0);
      check("t6_stray_issued", issued_cnt, 0);

      // Random programs: model is the ordered list of instructions before the first marker
      for (int b = 0; b < 25; b++) begin
         do_flush();
         k = $urandom_range(1, 8);
         marker_at = -1;
         for (int i = 0; i < k; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            d = {op, 24'($urandom)};
            push(d);
            if (marker_at < 0) begin
               if (op == 3'b000) marker_at = i;
               else exp_q.push_back(d);
            end
         end
         n_iss = exp_q.size();
         remain = (marker_at < 0) ? 0 : k - marker_at - 1;
         p0 = prog_cnt;
         run = 1'b1;
         for (int j = 0; j < n_iss; j++) serve_one($urandom_range(0, 3), $urandom_range(0, 5));
         wait_prog(seen);
         run = 1'b0;
         check("rnd_prog_seen", seen, 1);
         repeat (2) tick();
         check("rnd_issued", issued_cnt, n_iss);
         check("rnd_remain", host_count, remain);
         check("rnd_prog_once", prog_cnt - p0, 1);
         check("rnd_busy", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Buffers macro-instructions written by the host and issues them one at a time to the accelerator controller on the `inst`/`inst_valid` pair.
- The controller samples `inst` in its fetch state and runs each instruction to completion before fetching the next. This block therefore keeps exactly one instruction in flight and waits for the completion pulse before issuing again.
- An all-zero opcode acts as an end-of-program marker.

Parameters:
- INST_WIDTH, 27, instruction width; opcode = bits [INST_WIDTH-1:INST_WIDTH-3].
- DEPTH, 8, FIFO entries; must be a power of two.
- PTR_W, 3, log2(DEPTH).
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- host_wr_en  in  1  push request, one instruction per cycle
- host_wr_data  in  INST_WIDTH  instruction to push
- host_full  out  1  FIFO full (registered)
- host_count  out  PTR_W+1  number of FIFO entries (registered)
- run  in  1  level; enables issue
- flush  in  1  synchronous clear of FIFO, FSM and status
- inst  out  INST_WIDTH  instruction presented to controller
- inst_valid  out  1  inst is valid
- inst_accept  in  1  one-cycle pulse: controller latched inst
- inst_done  in  1  one-cycle pulse: controller finished the instruction
- busy  out  1  FSM not in IDLE
- prog_done  out  1  one-cycle pulse: end marker consumed, or queue drained
- issued_cnt  out  CNT_W  instructions issued since reset/flush; wraps
- err_overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset: clk; reset rstn, asynchronous, active-low. All outputs go to 0; FIFO pointers go to 0; FSM goes to IDLE.
- All outputs are registered.
- FIFO:
  - Circular buffer with read/write pointers of PTR_W+1 bits.
  - full when the pointers differ only in the MSB; empty when equal.
  - A push is accepted when host_wr_en is high and either the FIFO is not full or a pop occurs in the same cycle.
  - A push onto a full FIFO without a simultaneous pop is dropped and sets err_overflow.
  - host_count reflects push/pop activity one cycle later.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - inst_valid = 0.
  - If run = 1, FIFO not empty, and the head opcode ≠ 3'b000: load inst ← head, set inst_valid ← 1, go to ISSUE. inst_valid is seen one cycle after the condition.
  - If run = 1 and the head opcode = 3'b000: pop the marker, pulse prog_done, stay in IDLE. Nothing is issued and issued_cnt is unchanged.
- ISSUE:
  - inst and inst_valid are held stable.
  - On inst_accept: pop the head, clear inst_valid next cycle, increment issued_cnt, go to WAIT_DONE.
  - run falling in ISSUE does not withdraw inst; the instruction stays offered until accepted.
- WAIT_DONE:
  - inst_valid = 0.
  - On inst_done, with run = 1 and the FIFO non-empty: go to IDLE. The next issue decision, including marker handling, is made there, giving one bubble cycle.
  - On inst_done, with the FIFO empty: go to IDLE and pulse prog_done.
  - On inst_done, with run = 0: go to IDLE with no prog_done.
- busy = (state ≠ IDLE).
- Ignored events: inst_accept outside ISSUE; inst_done outside WAIT_DONE.
- Simultaneous inst_done and inst_accept are impossible by protocol; inst_accept takes priority if seen.
- flush, priority over everything except reset:
  - Empties the FIFO, clears inst_valid/inst, issued_cnt and err_overflow.
  - FSM goes to IDLE; any pending push in the same cycle is discarded.
  - Asserting flush while busy = 1 abandons tracking of the in-flight instruction. Software must only flush when busy = 0.
- issued_cnt wraps modulo 2^CNT_W.

Test Plan:
1. Reset, push 3 instructions (opcodes 110, 100, 110), run = 1; controller model accepts 1 cycle after inst_valid and returns done 5 cycles later.
   - Required: inst shows the three values in order, inst_valid high only in ISSUE, issued_cnt = 3.
   - Required: prog_done pulses once after the 3rd done, busy = 0, host_count = 0.
2. Push 9 instructions with run = 0.
   - Required: host_full = 1 after 8 pushes, 9th dropped, err_overflow = 1, host_count = 8.
   - Required: flush → host_count = 0, err_overflow = 0.
3. Full FIFO with ISSUE active; push in the same cycle as inst_accept.
   - Required: push accepted, host_count stays 8, err_overflow stays 0.
4. Push {110, marker 000, 100} and run.
   - Required: one issue, prog_done pulses when the marker is popped, the 100 instruction stays queued (host_count = 1).
5. Drop run while in ISSUE.
   - Required: inst held until accept, then done returns the FSM to IDLE with no new issue and no prog_done.
   - Required: raise run again → issue resumes.
6. Assert rstn low mid-WAIT_DONE.
   - Required: all outputs 0 immediately; spurious inst_done after release is ignored.
